// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - geometry shared by the 64x8 single-port RAM and its FIFO controller
package sp_ram_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;
endpackage

// File: rtl/sp_ram_fifo_ctrl.sv
// rtl/sp_ram_fifo_ctrl.sv - valid/ready byte FIFO on a single-port RAM with 1-cycle read latency
module sp_ram_fifo_ctrl #(
    parameter int DATA_W = sp_ram_pkg::DATA_W,
    parameter int ADDR_W = sp_ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              rd_iss;
    logic              in_rdy;
    logic              wr_en;

    always_comb begin
        // A read issues only when the output register is guaranteed free at capture time.
        rd_iss      = (count_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
        in_rdy      = rst_n && (count_q != FULL_CNT) && !rd_iss;
        wr_en       = in_valid && in_rdy;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_pend_d   = rd_iss;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (rd_iss) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        if (rd_pend_q) begin
            out_data_d  = ram_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_rdy;
    assign ram_we    = wr_en;
    assign ram_addr  = rd_iss ? rd_ptr_q : wr_ptr_q;
    assign ram_data  = in_data;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0) && !rd_pend_q && !out_valid_q;
endmodule
